// File: rtl/shift_register_pkg.sv
// Shared definitions for the left-shift register: default width, operation
// codes and the load/shift priority decoder.
package shift_register_pkg;

  localparam int unsigned DEFAULT_SR_WIDTH = 4;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_SHIFT = 2'd1,
    SR_LOAD  = 2'd2
  } sr_op_e;

  // Load outranks shift; neither enable asserted means hold.
  function automatic sr_op_e sr_decode(input logic load, input logic shift_en);
    sr_op_e op;
    op = SR_HOLD;
    if (load) begin
      op = SR_LOAD;
    end else if (shift_en) begin
      op = SR_SHIFT;
    end
    return op;
  endfunction

endpackage : shift_register_pkg

// File: rtl/shift_register.sv
// Parameterised left-shift register with synchronous parallel load, serial
// shift-in at the LSB and serial shift-out from the MSB.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_SR_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset_N,
  input  logic [WIDTH-1:0] Parallel_In,
  input  logic             Load,
  input  logic             Shift_Enable,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] Reg_Content,
  output logic             Shift_Out
);

  logic [WIDTH-1:0] content_q;
  logic [WIDTH-1:0] content_d;
  sr_op_e           op_c;

  // Next-state mux driven by the priority decoder.
  always_comb begin
    content_d = content_q;
    op_c      = sr_decode(Load, Shift_Enable);
    unique case (op_c)
      SR_LOAD:  content_d = Parallel_In;
      SR_SHIFT: content_d = {content_q[WIDTH-2:0], Shift_In};
      default:  content_d = content_q;
    endcase
  end

  // Synchronous active-low reset overrides load and shift.
  always_ff @(posedge CLK) begin
    if (!Reset_N) begin
      content_q <= '0;
    end else begin
      content_q <= content_d;
    end
  end

  assign Reg_Content = content_q;
  // Bit that the next shift will discard; no extra flop.
  assign Shift_Out   = content_q[WIDTH-1];

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: a driver pushes expected register
// values from an arithmetic model, a monitor pops and compares after each edge.
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int unsigned W    = DEFAULT_SR_WIDTH;
  localparam int unsigned MASK = (32'd1 << W) - 32'd1;

  typedef struct {
    int unsigned val;
    bit          so;
    string       nm;
  } exp_t;

  logic         CLK = 1'b0;
  logic         Reset_N = 1'b0;
  logic [W-1:0] Parallel_In = '0;
  logic         Load = 1'b0;
  logic         Shift_Enable = 1'b0;
  logic         Shift_In = 1'b0;
  logic [W-1:0] Reg_Content;
  logic         Shift_Out;

  exp_t        sb_q[$];
  int unsigned model = 0;
  int          checks = 0;
  int          failures = 0;

  shift_register #(.WIDTH(W)) dut (
    .CLK          (CLK),
    .Reset_N      (Reset_N),
    .Parallel_In  (Parallel_In),
    .Load         (Load),
    .Shift_Enable (Shift_Enable),
    .Shift_In     (Shift_In),
    .Reg_Content  (Reg_Content),
    .Shift_Out    (Shift_Out)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and push the value the register must hold after the edge.
  task automatic step(input bit rst_n, input bit ld, input bit se, input bit si,
                      input int unsigned pin, input string nm);
    sr_op_e op;
    @(negedge CLK);
    Reset_N      = rst_n;
    Load         = ld;
    Shift_Enable = se;
    Shift_In     = si;
    Parallel_In  = W'(pin);
    if (ld)      op = SR_LOAD;
    else if (se) op = SR_SHIFT;
    else         op = SR_HOLD;
    if (!rst_n) begin
      model = 0;
    end else begin
      case (op)
        SR_LOAD:  model = pin & MASK;
        SR_SHIFT: model = ((model * 2) + (si ? 1 : 0)) & MASK;
        default:  model = model;
      endcase
    end
    sb_q.push_back('{val: model, so: ((model >> (W - 1)) % 2) == 1, nm: nm});
  endtask

  // Monitor: compare after every edge for which an expectation was queued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (Reg_Content !== W'(e.val) || Shift_Out !== e.so) begin
          failures++;
          $display("FAIL %s: got Reg_Content=%h Shift_Out=%b, expected %h/%b",
                   e.nm, Reg_Content, Shift_Out, W'(e.val), e.so);
        end
      end
    end
  end

  initial begin : driver
    // Reset beats a pending load.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hF, "reset_vs_load");
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hF, "reset_vs_load");

    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, i, "load_sweep");

    // Shift pattern 1,0,1,1 into zero, then two zero shifts.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "shift_preload");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "shift_1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hF, "shift_2");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "shift_5");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hF, "shift_B");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, "shift_6");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, "shift_first_bit_out");

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h9, "hold_preload");
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 1'b0, 1'($urandom), $urandom & MASK, "hold");

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h3, "simul_preload");
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hC, "simul_load_wins");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'($urandom), i, "simul_sweep");

    // Mid-operation reset then resume from zero.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hE, "pre_reset_load");
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, "mid_reset");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "resume_shift");

    for (int i = 0; i < 1000; i++)
      step(($urandom % 32) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom & MASK, "random");

    repeat (3) @(negedge CLK);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_register
